ssd_scan_ctrl: RTL
==================

# ssd_scan_ctrl

Four-digit seven-segment scan controller. It consumes the single-cycle scan strobe produced by the frequency divider and time-multiplexes a BCD display word onto shared segment lines. New display values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits. A programmable blanking gap after every digit switch suppresses ghosting.

## Interface
- BLANK_CYC, 16, clk cycles of all-digits-off after each digit switch (0..255; 0 = no gap)
- clk  in  1  global clock
- rst_n  in  1  reset, asynchronous, active-low
- scan_en  in  1  one-clk scan strobe; advances the digit index
- in_valid  in  1  display word offered
- in_ready  out  1  controller can accept a word
- in_bcd  in  16  four BCD digits; [15:12] is digit 3 (most significant), [3:0] is digit 0
- in_dp  in  4  decimal-point enables, bit i goes to digit i
- lz_en  in  1  leading-zero blanking enable (level, sampled every cycle)
- ssd_ctl  out  4  digit enables, active-low, bit i = digit i
- ssd_seg  out  8  segments, active-low, [7:1] = a..g, [0] = dp
- frame_done  out  1  one-clk pulse when the digit index wraps 3->0

## Operation
- Registers: pending word (bcd+dp) with a pending_full flag; active word; 2-bit digit index idx; 8-bit blank_cnt.
- Handshake: in_ready = ~pending_full. When in_valid & in_ready at an edge, the word is captured into pending and pending_full sets. in_valid with in_ready low is held off; in_bcd/in_dp stay stable until accepted.
- Scan: an edge with scan_en=1 sets idx <= idx+1 (mod 4), blank_cnt <= BLANK_CYC, ssd_ctl <= 4'b1111, ssd_seg <= 8'hFF.
- Frame boundary: a scan_en edge with idx==3 pulses frame_done for one cycle. If pending_full, active <= pending and pending_full clears at the same edge, so in_ready is high in the next cycle.
- Same-edge accept and wrap: the transfer uses the old pending contents. A word accepted at that edge can only be accepted when pending is empty, so it goes to pending and is shown from the following frame.
- Blank phase: on every edge without scan_en where blank_cnt>0, blank_cnt decrements and the outputs stay blank.
- Drive phase: on an edge without scan_en where blank_cnt==0, ssd_ctl <= ~(1<<idx) and ssd_seg <= decode(active digit idx). These outputs hold until the next scan_en.
- scan_en during blank: restarts blank_cnt and advances idx. No error condition.
- Decode (bits [7:1]):
  - digits 0-9: 0x03, 0x9F, 0x25, 0x0D, 0x99, 0x49, 0x41, 0x1F, 0x01, 0x09
  - codes 0xA-0xF: dash, 0xFD
  - dp: bit 0 = ~dp[idx]
- Leading-zero blanking: with lz_en=1, digit k (k=3..1) shows segments off (0xFF) when digit k and every higher active digit equal 0. The dp bit still applies. Digit 0 is never blanked.

## Timing
- Reset values: ssd_ctl=4'b1111, ssd_seg=8'hFF, in_ready=1, frame_done=0, idx=0, blank_cnt=0, active=16'h0000/dp 0, pending_full=0.
- The first scan_en after reset moves idx to 1. Digit 0 is first driven only after three more scan strobes (3->0 wrap).
- Latency from the scan_en edge to digit visible: BLANK_CYC+1 edges. With BLANK_CYC=0, visible at the next edge.
- Latency from accept to display: pending until the next 3->0 wrap. Maximum one frame plus the current frame.
- All outputs are registered. Asserting rst_n mid-frame blanks the display immediately and drops the pending word.

## Test plan
- Reset, then hold scan_en low: ssd_ctl=4'b1111, ssd_seg=8'hFF, in_ready=1 indefinitely.
- Load 16'h1234 (dp=4'b0100) and run 8 scan strobes at BLANK_CYC=2. Required response:
  - frame_done pulses on each 3->0 wrap.
  - After the first wrap, digit 0 shows 0x99, digit 1 shows 0x0D, digit 2 shows 0x24 (dp set), digit 3 shows 0x9F.
  - Each digit is blank for exactly 3 edges after its strobe.
- Back-to-back loads 16'h1111 then 16'h2222 with no wrap in between: in_ready drops after the first accept and stays low. The second word is accepted the cycle after the wrap; the display shows 1111 for one frame, then 2222.
- lz_en=1 with 16'h0050: digits 3 and 2 show 0xFF, digit 1 shows 0x49, digit 0 shows 0x03. With lz_en=0, digits 3 and 2 show 0x03.
- Word 16'hA0F9: digits 3 and 1 show 0xFD, digit 2 shows 0x03, digit 0 shows 0x09.
- Assert rst_n low while digit 2 is driven and pending_full=1: outputs go to 0xFF/4'b1111 asynchronously. After release, in_ready=1 and the active word is 0000.

Source files
------------

// File: rtl/ssd_scan_ctrl_if.sv
// Display-word handshake into the seven-segment scan controller.
// A word is transferred on any clock edge where in_valid and in_ready are both high.
interface ssd_scan_ctrl_if;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned DP_W  = 4;

  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] in_bcd;
  logic [DP_W-1:0]  in_dp;

  modport master (
    output in_valid,
    output in_bcd,
    output in_dp,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_bcd,
    input  in_dp,
    output in_ready
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: time-multiplexes a BCD word onto shared
// active-low segment lines, swapping in new words only at frame boundaries.
module ssd_scan_ctrl #(
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           scan_en,
  input  logic           lz_en,
  ssd_scan_ctrl_if.slave in_if,
  output logic [3:0]     ssd_ctl,
  output logic [7:0]     ssd_seg,
  output logic           frame_done
);

  localparam int unsigned DIG_N = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = DIG_N * DIG_W;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned CNT_W = 8;

  // IDLE holds the display dark after reset until the first scan strobe.
  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_e;

  // Segment pattern a..g (active-low) for one BCD code; non-decimal codes show a dash.
  function automatic logic [6:0] seg7(input logic [DIG_W-1:0] dig);
    logic [6:0] pat;
    case (dig)
      4'd0:    pat = 7'h01;
      4'd1:    pat = 7'h4F;
      4'd2:    pat = 7'h12;
      4'd3:    pat = 7'h06;
      4'd4:    pat = 7'h4C;
      4'd5:    pat = 7'h24;
      4'd6:    pat = 7'h20;
      4'd7:    pat = 7'h0F;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h04;
      default: pat = 7'h7E;
    endcase
    return pat;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic [BCD_W-1:0]   pend_bcd_q, pend_bcd_d;
  logic [DIG_N-1:0]   pend_dp_q, pend_dp_d;
  logic               pend_full_q, pend_full_d;
  logic [BCD_W-1:0]   act_bcd_q, act_bcd_d;
  logic [DIG_N-1:0]   act_dp_q, act_dp_d;
  logic [DIG_N-1:0]   ctl_q, ctl_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               frame_done_q, frame_done_d;
  logic               in_ready_q, in_ready_d;

  logic               accept_c;
  logic [DIG_W-1:0]   cur_dig_c;
  logic [DIG_N-1:0]   lz_zero_c;
  logic               lz_blank_c;
  logic [DIG_N-1:0]   drive_ctl_c;
  logic [SEG_W-1:0]   drive_seg_c;

  assign accept_c = in_if.in_valid & in_ready_q;

  // lz_zero_c[k]: digit k and every more significant digit of the active word are zero.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lz_zero_c = '0;
    for (int k = DIG_N - 1; k >= 0; k--) begin
      all_zero     = all_zero & (act_bcd_q[DIG_W*k +: DIG_W] == '0);
      lz_zero_c[k] = all_zero;
    end
  end

  // Pattern for the currently selected digit; the decimal point survives zero blanking.
  always_comb begin
    cur_dig_c   = act_bcd_q[DIG_W*idx_q +: DIG_W];
    lz_blank_c  = lz_en & (idx_q != '0) & lz_zero_c[idx_q];
    drive_ctl_c = ~(DIG_N'(1) << idx_q);
    drive_seg_c = {(lz_blank_c ? 7'h7F : seg7(cur_dig_c)), ~act_dp_q[idx_q]};
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    blank_cnt_d  = blank_cnt_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_full_d  = pend_full_q;
    act_bcd_d    = act_bcd_q;
    act_dp_d     = act_dp_q;
    ctl_d        = ctl_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;

    if (scan_en) begin
      idx_d       = idx_q + IDX_W'(1);
      blank_cnt_d = CNT_W'(BLANK_CYC);
      ctl_d       = '1;
      seg_d       = '1;
      state_d     = S_BLANK;
      // Wrap 3->0: the frame boundary is the only point where the active word changes.
      if (idx_q == IDX_W'(DIG_N - 1)) begin
        frame_done_d = 1'b1;
        if (pend_full_q) begin
          act_bcd_d   = pend_bcd_q;
          act_dp_d    = pend_dp_q;
          pend_full_d = 1'b0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_BLANK: begin
          if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - CNT_W'(1);
          end else begin
            ctl_d   = drive_ctl_c;
            seg_d   = drive_seg_c;
            state_d = S_DRIVE;
          end
        end
        S_DRIVE: begin
          ctl_d = drive_ctl_c;
          seg_d = drive_seg_c;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Accept only ever happens into an empty pending slot, so it never collides with the transfer.
    if (accept_c) begin
      pend_bcd_d  = in_if.in_bcd;
      pend_dp_d   = in_if.in_dp;
      pend_full_d = 1'b1;
    end

    in_ready_d = ~pend_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      blank_cnt_q  <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
      ctl_q        <= '1;
      seg_q        <= '1;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      blank_cnt_q  <= blank_cnt_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      act_bcd_q    <= act_bcd_d;
      act_dp_q     <= act_dp_d;
      ctl_q        <= ctl_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign ssd_ctl         = ctl_q;
  assign ssd_seg         = seg_q;
  assign frame_done      = frame_done_q;
  assign in_if.in_ready  = in_ready_q;

endmodule
